// File: rtl/load_store_unit.sv
// Load/store unit: splits one load/store command into big-endian
// byte transfers over a req/ack link and reassembles load results.
module load_store_unit #(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic              sign_q, sign_d;
  logic [2:0]        n_q, n_d;
  logic [1:0]        k_q, k_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wsh_q, wsh_d;
  logic [23:0]       acc_q, acc_d;
  logic [31:0]       ld_q, ld_d;
  logic              mis_q, mis_d;

  logic              dec_legal;
  logic              dec_store;
  logic              dec_sign;
  logic [2:0]        dec_n;
  logic              dec_align;
  logic              last;
  logic [31:0]       ld_ext;
  logic              unused_addr;

  assign unused_addr = ^addr[31:MEM_AW];

  // Opcode decode: legality, direction, extension and byte count
  always_comb begin
    dec_legal = 1'b1;
    dec_store = 1'b0;
    dec_sign  = 1'b0;
    dec_n     = 3'd1;
    case (opcode)
      OP_LB: dec_sign = 1'b1;
      OP_LH: begin
        dec_sign = 1'b1;
        dec_n    = 3'd2;
      end
      OP_LW:  dec_n = 3'd4;
      OP_LBU: dec_n = 3'd1;
      OP_LHU: dec_n = 3'd2;
      OP_SB:  dec_store = 1'b1;
      OP_SH: begin
        dec_store = 1'b1;
        dec_n     = 3'd2;
      end
      OP_SW: begin
        dec_store = 1'b1;
        dec_n     = 3'd4;
      end
      default: dec_legal = 1'b0;
    endcase
    dec_align = 1'b1;
    if (dec_n == 3'd2) dec_align = ~addr[0];
    if (dec_n == 3'd4) dec_align = (addr[1:0] == 2'b00);
  end

  assign last = ({1'b0, k_q} == (n_q - 3'd1));

  // Final byte joins the accumulator; extend to 32 bits by size/sign
  always_comb begin
    ld_ext = {acc_q, mem_rdata};
    case (n_q)
      3'd1: ld_ext = {{24{sign_q & mem_rdata[7]}}, mem_rdata};
      3'd2: ld_ext = {{16{sign_q & acc_q[7]}}, acc_q[7:0], mem_rdata};
      default: ld_ext = {acc_q, mem_rdata};
    endcase
  end

  // Next-state logic for the command sequencer
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    sign_d  = sign_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wsh_d   = wsh_q;
    acc_d   = acc_q;
    ld_d    = ld_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          store_d = dec_store;
          sign_d  = dec_sign;
          n_d     = dec_n;
          k_d     = 2'd0;
          addr_d  = addr[MEM_AW-1:0];
          acc_d   = 24'h0;
          wsh_d   = 32'h0;
          if (dec_store) begin
            case (dec_n)
              3'd1: wsh_d = {store_data[7:0], 24'h0};
              3'd2: wsh_d = {store_data[15:0], 16'h0};
              default: wsh_d = store_data;
            endcase
          end
          if (dec_legal && dec_align) begin
            mis_d   = 1'b0;
            state_d = XFER;
          end else begin
            mis_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      XFER: begin
        if (mem_ack) begin
          if (last) begin
            state_d = DONE;
            if (!store_q) ld_d = ld_ext;
          end else begin
            k_d    = k_q + 2'd1;
            addr_d = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
            wsh_d  = {wsh_q[23:0], 8'h0};
            acc_d  = {acc_q[15:0], mem_rdata};
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      sign_q  <= 1'b0;
      n_q     <= 3'd1;
      k_q     <= 2'd0;
      addr_q  <= '0;
      wsh_q   <= 32'h0;
      acc_q   <= 24'h0;
      ld_q    <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      sign_q  <= sign_d;
      n_q     <= n_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wsh_q   <= wsh_d;
      acc_q   <= acc_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_req   = (state_q == XFER);
  assign mem_we    = mem_req & store_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wsh_q[31:24];
  assign load_data = ld_q;
  assign misalign  = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory responder plus a
// reference model of command semantics and timing.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, misalign;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b1;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data),
    .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  logic [7:0] tb_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] xa_q [$];
  logic       xw_q [$];
  logic [7:0] xd_q [$];
  int         ack_mode = 0;
  int         ws_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [31:0] exp_ld = 32'h0;

  assign mem_rdata = mem_ack ? tb_mem[mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      xa_q.push_back(mem_addr);
      xw_q.push_back(mem_we);
      xd_q.push_back(mem_wdata);
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (!mem_req || mem_ack) ws_cnt <= 0;
    else ws_cnt <= ws_cnt + 1;
  end

  always @(negedge clk) begin
    case (ack_mode)
      0: mem_ack = 1'b1;
      1: mem_ack = ($urandom_range(0, 2) != 0);
      default: mem_ack = (ws_cnt == 2);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void decode(input logic [5:0] op, output bit legal,
                                 output bit st, output bit sgn,
                                 output int n);
    legal = 1; st = 0; sgn = 0; n = 1;
    case (op)
      6'b100000: begin sgn = 1; n = 1; end
      6'b100001: begin sgn = 1; n = 2; end
      6'b100011: n = 4;
      6'b100100: n = 1;
      6'b100101: n = 2;
      6'b101000: begin st = 1; n = 1; end
      6'b101001: begin st = 1; n = 2; end
      6'b101011: begin st = 1; n = 4; end
      default: legal = 0;
    endcase
  endfunction

  task automatic run_cmd(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d, input bit poke,
                         output int dcyc, output int rfirst,
                         output int rlast, output int ndone,
                         output logic [31:0] ld_at, output logic mis_at);
    xa_q.delete(); xw_q.delete(); xd_q.delete();
    dcyc = 0; rfirst = 0; rlast = 0; ndone = 0;
    ld_at = 32'h0; mis_at = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = op; addr = a; store_data = d;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1 && poke) begin
        start = 1'b1; opcode = 6'b100011; addr = 32'h0;
      end else begin
        start = 1'b0;
      end
      if (mem_req) begin
        if (rfirst == 0) rfirst = c;
        rlast = c;
      end
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = c; ld_at = load_data; mis_at = misalign;
        end
      end
      if (dcyc != 0 && c >= dcyc + 3) break;
    end
  endtask

  task automatic run_check(input string tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] d,
                           input bit poke, input int want_dcyc,
                           input int want_rlast);
    bit legal, st, sgn, err;
    int n, nx, dcyc, rfirst, rlast, ndone;
    logic [31:0] ld_at, val, b;
    logic mis_at;
    logic [7:0] ba;
    decode(op, legal, st, sgn, n);
    err = !legal || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    run_cmd(op, a, d, poke, dcyc, rfirst, rlast, ndone, ld_at, mis_at);
    nx = err ? 0 : n;
    chk({tag, ".ndone"}, ndone, 1);
    chk({tag, ".mis"}, 32'(mis_at), 32'(err));
    chk({tag, ".nxfer"}, xa_q.size(), nx);
    chk({tag, ".idle"}, 32'(busy), 0);
    val = 32'h0;
    for (int k = 0; k < nx; k++) begin
      ba = 8'(a + 32'(k));
      if (st) begin
        b = (d >> (8 * (n - 1 - k))) & 32'hFF;
        ref_mem[ba] = b[7:0];
      end else begin
        val = (val << 8) | 32'(ref_mem[ba]);
      end
      if (k < xa_q.size()) begin
        chk({tag, ".addr"}, 32'(xa_q[k]), 32'(ba));
        chk({tag, ".we"}, 32'(xw_q[k]), 32'(st));
        if (st) chk({tag, ".wdata"}, 32'(xd_q[k]), b);
      end
    end
    if (!err && !st) begin
      if (sgn && n == 1 && val[7]) val = val | 32'hFFFFFF00;
      if (sgn && n == 2 && val[15]) val = val | 32'hFFFF0000;
      exp_ld = val;
    end
    chk({tag, ".ld"}, ld_at, exp_ld);
    if (want_dcyc > 0) chk({tag, ".dcyc"}, dcyc, want_dcyc);
    if (want_rlast >= 0) begin
      chk({tag, ".rfirst"}, rfirst, (nx == 0) ? 0 : 1);
      chk({tag, ".rlast"}, rlast, want_rlast);
    end
  endtask

  initial begin
    logic [5:0]  ops [8];
    logic [5:0]  op;
    logic [31:0] a;
    int          bad, dseen;

    ops[0] = 6'b100000; ops[1] = 6'b100001; ops[2] = 6'b100011;
    ops[3] = 6'b100100; ops[4] = 6'b100101; ops[5] = 6'b101000;
    ops[6] = 6'b101001; ops[7] = 6'b101011;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[8'h20] = 8'h80; ref_mem[8'h20] = 8'h80;
    tb_mem[8'h21] = 8'h01; ref_mem[8'h21] = 8'h01;

    #12;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.ld", load_data, 0);
    chk("rst.mis", 32'(misalign), 0);
    chk("rst.req", 32'(mem_req), 0);
    chk("rst.we", 32'(mem_we), 0);
    chk("rst.addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("sw10", 6'b101011, 32'h10, 32'hDEADBEEF, 0, 5, 4);
    run_check("lw10", 6'b100011, 32'h10, 32'h0, 0, 5, 4);
    chk("lw10.val", load_data, 32'hDEADBEEF);

    run_check("lb20", 6'b100000, 32'h20, 32'h0, 0, 2, 1);
    chk("lb20.val", load_data, 32'hFFFFFF80);
    run_check("lbu20", 6'b100100, 32'h20, 32'h0, 0, 2, 1);
    chk("lbu20.val", load_data, 32'h00000080);
    run_check("lh20", 6'b100001, 32'h20, 32'h0, 0, 3, 2);
    chk("lh20.val", load_data, 32'hFFFF8001);
    run_check("lhu20", 6'b100101, 32'h20, 32'h0, 0, 3, 2);
    chk("lhu20.val", load_data, 32'h00008001);

    ack_mode = 2;
    run_check("lwws", 6'b100011, 32'h10, 32'h0, 0, 13, 12);
    chk("lwws.val", load_data, 32'hDEADBEEF);
    ack_mode = 0;

    run_check("lh21", 6'b100001, 32'h21, 32'h0, 0, 1, 0);
    run_check("sw22", 6'b101011, 32'h22, 32'h12345678, 0, 1, 0);
    run_check("op0", 6'b000000, 32'h20, 32'h0, 0, 1, 0);
    chk("err.ld", load_data, 32'hDEADBEEF);
    run_check("clr", 6'b100100, 32'h21, 32'h0, 0, 2, 1);
    chk("clr.mis", 32'(misalign), 0);

    run_check("swwrap", 6'b101011, 32'h1FC, 32'hA1B2C3D4, 1, 5, 4);

    for (int i = 0; i < 4; i++) begin
      tb_mem[8'h40 + 8'(i)] = 8'h00;
      ref_mem[8'h40 + 8'(i)] = 8'h00;
    end
    @(negedge clk);
    start = 1'b1; opcode = 6'b101011;
    addr = 32'h40; store_data = 32'h11223344;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rmid.req3", 32'(mem_req), 1);
    chk("rmid.addr3", 32'(mem_addr), 32'h42);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid.req", 32'(mem_req), 0);
    chk("rmid.busy", 32'(busy), 0);
    chk("rmid.done", 32'(done), 0);
    dseen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("rmid.nodone", dseen, 0);
    chk("rmid.m40", 32'(tb_mem[8'h40]), 32'h11);
    chk("rmid.m41", 32'(tb_mem[8'h41]), 32'h22);
    chk("rmid.m42", 32'(tb_mem[8'h42]), 32'h00);
    chk("rmid.m43", 32'(tb_mem[8'h43]), 32'h00);
    chk("rmid.ld", load_data, 32'h0);
    ref_mem[8'h40] = 8'h11;
    ref_mem[8'h41] = 8'h22;
    exp_ld = 32'h0;

    ack_mode = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_check("rnd", op, a, $urandom, 0, -1, -1);
    end
    ack_mode = 0;
    @(negedge clk);
    @(negedge clk);

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (tb_mem[i] !== ref_mem[i]) bad++;
    chk("memimg", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
